// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit data-memory port to a 16-bit SRAM.
// Each 32-bit access is split into two half-word accesses (low then high)
// with a fixed five-cycle occupancy. ready doubles as the pipeline freeze.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_TAIL,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [17:0] addr_q, addr_d;
    logic        we_n_q, we_n_d;
    logic [31:0] rdata_q, rdata_d;

    logic [16:0] word;
    logic [15:0] dq_out;

    // Word index relative to the base; wraps silently into 17 bits.
    assign word = 17'((address - BASE_ADDR) >> 2);

    // Next-state, registered SRAM controls and read-capture logic.
    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        we_n_d  = we_n_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_en || rd_en) begin
                    state_d = S_LO;
                    is_wr_d = wr_en;
                    addr_d  = {word, 1'b0};
                    we_n_d  = ~wr_en;
                end
            end
            S_LO: begin
                state_d = S_HI;
                addr_d  = {word, 1'b1};
            end
            S_HI: begin
                state_d = S_TAIL;
                we_n_d  = 1'b1;
                if (!is_wr_q) begin
                    rdata_d[15:0] = SRAM_DQ;
                end
            end
            S_TAIL: begin
                state_d = S_DONE;
                if (!is_wr_q) begin
                    rdata_d[31:16] = SRAM_DQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                we_n_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            we_n_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            we_n_q  <= we_n_d;
            rdata_q <= rdata_d;
        end
    end

    // Write data follows the live input; the half is chosen by the phase.
    always_comb begin
        dq_out = write_data[15:0];
        if (state_q == S_HI) begin
            dq_out = write_data[31:16];
        end
    end

    // Bus is driven only while the write strobe is active.
    assign SRAM_DQ   = we_n_q ? 16'hzzzz : dq_out;

    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign read_data = rdata_q;
    assign ready     = ((state_q == S_IDLE) && !rd_en && !wr_en) || (state_q == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM, half-word reference model,
// directed vector table, reset/idle sequences and randomized traffic.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, ce_n, oe_n, we_n;

    int n_checks = 0;
    int n_fail   = 0;

    sram_controller #(.BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .SRAM_WE_N(we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: writes on the edge while WE_N is low, read address
    // registered on every edge, output driven whenever WE_N is high.
    bit   [15:0] mem [0:262143];
    logic [15:0] sram_out = 16'h0;
    always @(posedge clk) begin
        if (!we_n) mem[sram_addr] <= sram_dq;
        sram_out <= mem[sram_addr];
    end
    assign sram_dq = we_n ? sram_out : 16'hzzzz;

    // Reference model: half-word store indexed by SRAM half-word address.
    bit [15:0] ref_hw [int unsigned];
    logic [31:0] rd_model;

    function automatic logic [15:0] ref_get(input int unsigned i);
        return ref_hw.exists(i) ? ref_hw[i] : 16'h0;
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return (off / 4) % 131072;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Bus monitor: while WE_N is high only the SRAM may drive, and the bus
    // must never carry unknowns.
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            n_checks++;
            if (we_n && (sram_dq !== sram_out)) begin
                n_fail++;
                $display("FAIL bus_contention: dq %h expected sram %h", sram_dq, sram_out);
            end else if ($isunknown(sram_dq)) begin
                n_fail++;
                $display("FAIL bus_unknown: dq %h expected known value", sram_dq);
            end
        end
    end

    // One complete access starting at a negedge with the DUT idle; returns
    // at the negedge of the cycle after DONE with requests dropped.
    task automatic do_op(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input string tag);
        int unsigned wd;
        int k;
        wd = word_of(a);
        wr_en = w; rd_en = r; address = a; write_data = d;
        k = 0;
        while (1) begin
            #1;
            if (k == 1) begin
                check({tag, "_lo_addr"}, 32'(sram_addr), 32'(2 * wd));
                check({tag, "_lo_we"}, 32'(we_n), w ? 32'd0 : 32'd1);
                if (w) check({tag, "_lo_dq"}, 32'(sram_dq), 32'(d[15:0]));
            end else if (k == 2) begin
                check({tag, "_hi_addr"}, 32'(sram_addr), 32'(2 * wd + 1));
                check({tag, "_hi_we"}, 32'(we_n), w ? 32'd0 : 32'd1);
                if (w) check({tag, "_hi_dq"}, 32'(sram_dq), 32'(d[31:16]));
            end else if (k == 3) begin
                check({tag, "_tail_we"}, 32'(we_n), 32'd1);
            end
            if (ready) break;
            k++;
            if (k > 8) break;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(k), 32'd4);
        check({tag, "_read_data"}, read_data, exp_rd);
        if (w) begin
            ref_hw[2 * wd]     = d[15:0];
            ref_hw[2 * wd + 1] = d[31:16];
        end else begin
            rd_model = {ref_get(2 * wd + 1), ref_get(2 * wd)};
        end
        @(negedge clk);
        check({tag, "_mem_lo"}, 32'(mem[2 * wd]), 32'(ref_get(2 * wd)));
        check({tag, "_mem_hi"}, 32'(mem[2 * wd + 1]), 32'(ref_get(2 * wd + 1)));
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        vecs[0] = '{1'b1, 1'b0, 32'd1024,   32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1028,   32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 32'd1028,   32'h00000000, 32'h12345678};
        vecs[5] = '{1'b1, 1'b1, 32'd1032,   32'hA5A55A5A, 32'h12345678};
        vecs[6] = '{1'b0, 1'b1, 32'd1032,   32'h00000000, 32'hA5A55A5A};
        vecs[7] = '{1'b1, 1'b0, 32'd1036,   32'h0BADC0DE, 32'hA5A55A5A};
        vecs[8] = '{1'b1, 1'b0, 32'd0,      32'hCAFEF00D, 32'hA5A55A5A};
        vecs[9] = '{1'b0, 1'b1, 32'd524288, 32'h00000000, 32'hCAFEF00D};

        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        rd_model = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_read_data", read_data, 32'h0);
        check("reset_sram_addr", 32'(sram_addr), 32'h0);
        check("reset_we_n", 32'(we_n), 32'd1);
        check("reset_ready", 32'(ready), 32'd1);
        check("tied_enables", {28'h0, ub_n, lb_n, ce_n, oe_n}, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data,
                  vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end
        check("hw0", 32'(mem[0]), 32'h0000BEEF);
        check("hw1", 32'(mem[1]), 32'h0000DEAD);
        check("hw2", 32'(mem[2]), 32'h00005678);
        check("hw3", 32'(mem[3]), 32'h00001234);
        check("hw4", 32'(mem[4]), 32'h00005A5A);
        check("hw5", 32'(mem[5]), 32'h0000A5A5);
        check("hw_wrap", 32'(mem[18'h3FE00]), 32'h0000F00D);

        // Write of all-ones to 1036 aborted by reset sampled on the edge that
        // would enter HI: only the low half reaches the SRAM.
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hFFFFFFFF;
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        check("rst_mid_we_n", 32'(we_n), 32'd1);
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_read_data", read_data, 32'h0);
        rst = 1'b0;
        ref_hw[6] = 16'hFFFF;
        rd_model = '0;
        check("rst_mid_hw6", 32'(mem[6]), 32'h0000FFFF);
        check("rst_mid_hw7", 32'(mem[7]), 32'h00000BAD);
        @(negedge clk);
        do_op(1'b0, 1'b1, 32'd1036, 32'h0, 32'h0BADFFFF, "rd_after_rst");

        // Idle stretch with no request.
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_we_n", 32'(we_n), 32'd1);
            check("idle_addr", 32'(sram_addr), 32'd7);
            @(negedge clk);
        end

        // Randomized back-to-back traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            bit w, r;
            logic [31:0] a, d, e;
            int unsigned sel;
            sel = $urandom_range(0, 3);
            w = (sel == 0) || (sel == 3);
            r = (sel != 0);
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'd1024 + 4 * $urandom_range(0, 15);
            d = $urandom;
            e = w ? rd_model : {ref_get(2 * word_of(a) + 1), ref_get(2 * word_of(a))};
            do_op(w, r, a, d, e, $sformatf("rnd%0d", i));
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
